// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU program sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: opcode values, sequencer state encoding, 12-bit instruction word field positions.
package cpu_pkg;

  // Opcodes carried in instruction bits [11:8]
  localparam logic [3:0] OPC_ADD   = 4'h0;
  localparam logic [3:0] OPC_SUB   = 4'h1;
  localparam logic [3:0] OPC_STORE = 4'h2;
  localparam logic [3:0] OPC_LOAD  = 4'h3;
  localparam logic [3:0] OPC_AND   = 4'h5;
  localparam logic [3:0] OPC_OR    = 4'h6;
  localparam logic [3:0] OPC_XOR   = 4'h7;
  localparam logic [3:0] OPC_NOT   = 4'h8;
  localparam logic [3:0] OPC_SHL   = 4'h9;
  localparam logic [3:0] OPC_SHR   = 4'hA;
  localparam logic [3:0] OPC_JZ    = 4'hB;
  localparam logic [3:0] OPC_JMP   = 4'hC;
  localparam logic [3:0] OPC_HALT  = 4'hF;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;
  localparam logic [1:0] ST_ADVANCE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_FETCH   = ST_FETCH,
    S_ISSUE   = ST_ISSUE,
    S_ADVANCE = ST_ADVANCE
  } seq_state_t;

  // Instruction word layout: {opcode[11:8], addr[7:4], data[3:0]}
  localparam int INSTR_W  = 12;
  localparam int OPC_LSB  = 8;
  localparam int ADDR_LSB = 4;
  localparam int DATA_LSB = 0;

  // Word every slot holds after reset: HALT with zero operands
  localparam logic [INSTR_W-1:0] HALT_WORD = 12'hF00;

endpackage

// File: rtl/cpu_prog_store.sv
// Instruction store: DEPTH x W register file, synchronous write, asynchronous read.
// Latency: write visible on read port the cycle after the write edge; read is combinational.
// Backpressure: none; writer is gated by the sequencer.
// Ports: clk, rst (sync, active-high, reloads every slot with INIT_WORD),
//        wr_en/wr_addr/wr_data write port, rd_addr/rd_data read port.
module cpu_prog_store
  import cpu_pkg::*;
#(
  parameter int               DEPTH     = 16,
  parameter int               AW        = 4,
  parameter int               W         = INSTR_W,
  parameter logic [W-1:0]     INIT_WORD = HALT_WORD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_WORD;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_program_sequencer.sv
// Program sequencer: steps a PC through a loaded instruction store and issues words to the datapath.
// Latency: start -> cpu_valid after 2 edges; each issued instruction takes >= 3 cycles (FETCH/ISSUE/ADVANCE).
// Backpressure: fields held stable in ISSUE until cpu_valid && cpu_ready; abort drops back to IDLE at once.
// Ports: clk, rst (sync, active-high); load_en/load_addr/load_instr (IDLE only); start, abort, acc_zero;
//        cpu_valid/cpu_ready handshake with cpu_opcode/cpu_addr/cpu_data/cpu_we; busy, done, pc status.
// Build option: define CPUSEQ_BRANCH_EN to resolve JMP (4'hC) and JZ (4'hB) internally instead of issuing them.
module cpu_program_sequencer
  import cpu_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int PC_W       = 4,
  parameter int OPC_W      = 4,
  parameter int DATA_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [PC_W-1:0]           load_addr,
  input  logic [OPC_W+2*DATA_W-1:0] load_instr,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      acc_zero,
  input  logic                      cpu_ready,
  output logic                      cpu_valid,
  output logic [OPC_W-1:0]          cpu_opcode,
  output logic [DATA_W-1:0]         cpu_addr,
  output logic [DATA_W-1:0]         cpu_data,
  output logic                      cpu_we,
  output logic                      busy,
  output logic                      done,
  output logic [PC_W-1:0]           pc
);

  localparam int IW = OPC_W + 2 * DATA_W;

  seq_state_t          state;
  logic [IW-1:0]       rd_instr;
  logic [OPC_W-1:0]    f_opc;
  logic [DATA_W-1:0]   f_addr;
  logic [DATA_W-1:0]   f_data;
  logic                store_we;

  // Slots only change while idle, so a run always sees a frozen program
  assign store_we = load_en && (state == S_IDLE);

  cpu_prog_store #(
    .DEPTH     (PROG_DEPTH),
    .AW        (PC_W),
    .W         (IW),
    .INIT_WORD (IW'(HALT_WORD))
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store_we),
    .wr_addr (load_addr),
    .wr_data (load_instr),
    .rd_addr (pc),
    .rd_data (rd_instr)
  );

  assign f_opc  = rd_instr[OPC_LSB  +: OPC_W];
  assign f_addr = rd_instr[ADDR_LSB +: DATA_W];
  assign f_data = rd_instr[DATA_LSB +: DATA_W];

`ifndef CPUSEQ_BRANCH_EN
  // Branches are plain issued opcodes in this build; the flag is not consulted
  logic unused_acc_zero;
  assign unused_acc_zero = acc_zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      cpu_valid  <= 1'b0;
      cpu_opcode <= '0;
      cpu_addr   <= '0;
      cpu_data   <= '0;
      cpu_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort outranks everything, including a start in IDLE; pc is kept for inspection
        state     <= S_IDLE;
        cpu_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // A load in the same cycle as start takes priority and the start is dropped
            if (start && !load_en) begin
              state <= S_FETCH;
              pc    <= '0;
              busy  <= 1'b1;
            end
          end
          S_FETCH: begin
            if (f_opc == OPC_HALT) begin
              done  <= 1'b1;
              state <= S_IDLE;
              busy  <= 1'b0;
            end
`ifdef CPUSEQ_BRANCH_EN
            else if (f_opc == OPC_JMP) begin
              pc <= PC_W'(f_addr);
            end else if (f_opc == OPC_JZ) begin
              pc <= acc_zero ? PC_W'(f_addr) : pc + PC_W'(1);
            end
`endif
            else begin
              cpu_opcode <= f_opc;
              cpu_addr   <= f_addr;
              cpu_data   <= f_data;
              cpu_we     <= (f_opc == OPC_STORE);
              cpu_valid  <= 1'b1;
              state      <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (cpu_ready) begin
              cpu_valid <= 1'b0;
              state     <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            // Natural wrap at PROG_DEPTH keeps a HALT-free program looping
            pc    <= pc + PC_W'(1);
            state <= S_FETCH;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
module tb_cpu_program_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_instr;
  logic        start;
  logic        abort;
  logic        acc_zero;
  logic        cpu_ready;
  logic        cpu_valid;
  logic [3:0]  cpu_opcode;
  logic [3:0]  cpu_addr;
  logic [3:0]  cpu_data;
  logic        cpu_we;
  logic        busy;
  logic        done;
  logic [3:0]  pc;

  int checks   = 0;
  int failures = 0;

  // Reference program image and expected issue stream
  logic [11:0] prog_m [16];
  logic [11:0] exp_q[$];
  int          exp_pc_q[$];
  bit          exp_halt;
  int          halt_pc;
  logic [3:0]  ops[$];

  cpu_program_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_instr (load_instr),
    .start      (start),
    .abort      (abort),
    .acc_zero   (acc_zero),
    .cpu_ready  (cpu_ready),
    .cpu_valid  (cpu_valid),
    .cpu_opcode (cpu_opcode),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_we     (cpu_we),
    .busy       (busy),
    .done       (done),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] rand_word();
    logic [3:0] op;
    op = ops[$urandom_range(ops.size() - 1)];
    return {op, 4'($urandom_range(15)), 4'($urandom_range(15))};
  endfunction

  task automatic load_slot(input int a, input logic [11:0] w);
    load_en    = 1'b1;
    load_addr  = 4'(a);
    load_instr = w;
    prog_m[a]  = w;
    step();
    load_en    = 1'b0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) prog_m[i] = 12'hF00;
  endtask

  // Walk the program the way the sequencer should: issue order, pc per issue, HALT stop.
  task automatic build_model(input bit az, input int limit);
    int p;
    int steps;
    logic [11:0] w;
    p = 0;
    steps = 0;
    exp_q.delete();
    exp_pc_q.delete();
    exp_halt = 0;
    halt_pc = 0;
    while (exp_q.size() <= limit && steps < 200) begin
      w = prog_m[p];
      steps++;
      if (w[11:8] == 4'hF) begin
        exp_halt = 1;
        halt_pc = p;
        break;
      end
`ifdef CPUSEQ_BRANCH_EN
      if (w[11:8] == 4'hC) begin
        p = int'(w[7:4]);
        continue;
      end
      if (w[11:8] == 4'hB) begin
        p = az ? int'(w[7:4]) : (p + 1) % 16;
        continue;
      end
`endif
      exp_q.push_back(w);
      exp_pc_q.push_back(p);
      p = (p + 1) % 16;
    end
  endtask

  // Start a run and check every transfer against the model; abort after 'limit' issues if no HALT.
  task automatic run_prog(input string tag, input bit az, input int limit, input int rdy_pct,
                          input int stall_n, input bit poke, input bit lat);
    int          issued;
    int          dones;
    int          cyc;
    int          stall_left;
    bit          fin;
    bit          stalled;
    logic [11:0] held;
    logic [11:0] w;
    int          end_pc;
    issued = 0; dones = 0; cyc = 0; fin = 0; stalled = 0; held = '0; end_pc = 0;
    stall_left = stall_n;
    build_model(az, limit);
    acc_zero = az;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      cyc++;
      if (lat && cyc == 1) chk({tag, "_lat1"}, 32'(cpu_valid), 0);
      if (lat && cyc == 2) chk({tag, "_lat2"}, 32'(cpu_valid), 1);
      if (done) begin
        dones++;
        fin = 1;
      end else if (cpu_valid) begin
        w = {cpu_opcode, cpu_addr, cpu_data};
        if (stalled) chk({tag, "_stable"}, 32'(w), 32'(held));
        if (issued >= exp_q.size()) begin
          chk({tag, "_extra_issue"}, issued, exp_q.size());
          abort = 1'b1;
          fin = 1;
        end else begin
          chk({tag, "_pc"}, 32'(pc), exp_pc_q[issued]);
          if (issued == limit && !exp_halt) begin
            chk({tag, "_abort_word"}, 32'(w), 32'(exp_q[issued]));
            abort = 1'b1;
            cpu_ready = 1'b0;
            end_pc = exp_pc_q[issued];
            fin = 1;
          end else if (stall_left > 0) begin
            stall_left--;
            cpu_ready = 1'b0;
            held = w;
            stalled = 1;
          end else if ($urandom_range(99) < rdy_pct) begin
            cpu_ready = 1'b1;
            chk({tag, "_word"}, 32'(w), 32'(exp_q[issued]));
            chk({tag, "_we"}, 32'(cpu_we), 32'(exp_q[issued][11:8] == 4'h2));
            issued++;
            stalled = 0;
          end else begin
            cpu_ready = 1'b0;
            held = w;
            stalled = 1;
          end
        end
      end else begin
        cpu_ready = 1'($urandom_range(1));
      end
      if (poke && busy && !fin) begin
        load_en    = 1'($urandom_range(1));
        load_addr  = 4'($urandom_range(15));
        load_instr = 12'($urandom_range(4095));
        start      = 1'($urandom_range(1));
      end else begin
        load_en = 1'b0;
        start   = 1'b0;
      end
      step();
    end
    abort = 1'b0; cpu_ready = 1'b0; load_en = 1'b0; start = 1'b0;
    if (!fin) chk({tag, "_timeout"}, cyc, 0);
    chk({tag, "_done_cnt"}, dones, 32'(exp_halt));
    chk({tag, "_issued"}, issued, exp_halt ? exp_q.size() : limit);
    chk({tag, "_end_pc"}, 32'(pc), exp_halt ? halt_pc : end_pc);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_valid_end"}, 32'(cpu_valid), 0);
    chk({tag, "_done_end"}, 32'(done), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(cpu_valid), 0);
    chk({tag, "_opc"},   32'(cpu_opcode), 0);
    chk({tag, "_addr"},  32'(cpu_addr), 0);
    chk({tag, "_data"},  32'(cpu_data), 0);
    chk({tag, "_we"},    32'(cpu_we), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_pc"},    32'(pc), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
`ifdef CPUSEQ_BRANCH_EN
      if (i != 11 && i != 12 && i != 15) ops.push_back(4'(i));
`else
      if (i != 15) ops.push_back(4'(i));
`endif
    end
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_instr = '0;
    start = 1'b0; abort = 1'b0; acc_zero = 1'b0; cpu_ready = 1'b0;
    reset_model();
    step();
    step();
    rst = 1'b0;
    check_outputs_zero("reset");

    // Directed program: LOAD 3, ADD 5, STORE 7, HALT
    load_slot(0, 12'h330);
    load_slot(1, 12'h005);
    load_slot(2, 12'h270);
    load_slot(3, 12'hF00);
    run_prog("basic", 1'b0, 20, 100, 0, 1'b0, 1'b1);

    // Four cycles of backpressure on the first issue
    run_prog("stall", 1'b0, 20, 100, 4, 1'b0, 1'b0);

    // No HALT anywhere: run must wrap pc and reissue slot 0
    for (int i = 0; i < 16; i++) load_slot(i, rand_word());
    run_prog("wrap", 1'b0, 20, 100, 0, 1'b0, 1'b0);

    // Randomised programs, random backpressure, junk loads/starts while busy
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) load_slot(i, rand_word());
      if ($urandom_range(3) != 0) load_slot($urandom_range(1, 15), 12'hF00);
      run_prog("rand", 1'b0, 24, 60, 0, 1'b1, 1'b0);
    end

    // Load and start together in IDLE: the load lands, no run begins
    load_en = 1'b1; start = 1'b1; load_addr = 4'd0; load_instr = 12'h712;
    prog_m[0] = 12'h712;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("ldstart_busy1", 32'(busy), 0);
    step();
    chk("ldstart_busy2", 32'(busy), 0);
    chk("ldstart_valid", 32'(cpu_valid), 0);
    run_prog("ldstart_run", 1'b0, 24, 100, 0, 1'b0, 1'b0);

    // Abort beats start in IDLE
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", 32'(busy), 0);
    step();
    chk("abort_start_valid", 32'(cpu_valid), 0);

    // Reset in the middle of an issue
    for (int i = 0; i < 16; i++) load_slot(i, rand_word());
    start = 1'b1;
    step();
    start = 1'b0;
    cpu_ready = 1'b0;
    for (int i = 0; i < 10 && !cpu_valid; i++) step();
    chk("rstmid_pre_valid", 32'(cpu_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outputs_zero("rstmid");
    reset_model();
    run_prog("rst_slots", 1'b0, 4, 100, 0, 1'b0, 1'b0);

`ifdef CPUSEQ_BRANCH_EN
    for (int i = 0; i < 16; i++) load_slot(i, rand_word());
    load_slot(9, 12'hF00);
    load_slot(0, 12'hB50);
    run_prog("jz_taken", 1'b1, 6, 100, 0, 1'b0, 1'b0);
    run_prog("jz_not", 1'b0, 6, 100, 0, 1'b0, 1'b0);
    load_slot(0, 12'hC20);
    run_prog("jmp", 1'b0, 6, 100, 0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
